// File: rtl/fp_pkg.sv
// Shared types and helpers for the sequential radix-16 Booth multiplier.
package fp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_t;

   // Radix-16 digits needed to cover WIDTH unsigned bits plus the zero pad.
   function automatic int NUM_DIGITS(input int width);
      return (width + 1 + 3) / 4;
   endfunction

endpackage

// File: rtl/booth_mul_seq_radix16.sv
// Radix16_Booth: multiplicand multiple table and Booth digit select.
module Radix16_Booth #(
   parameter int WIDTH = 24
) (
   input  logic [WIDTH-1:0] Multiplicand,
   input  logic [4:0]       Multiplier,
   output logic [WIDTH+3:0] Partial
);

   localparam int PW = WIDTH + 4;

   logic [PW-1:0]     m1, m2, m3, m4;
   logic [PW-1:0]     m5, m6, m7, m8;
   logic [PW-1:0]     mag_pp;
   logic signed [4:0] digit;
   logic [4:0]        abs_d;
   logic              neg;

   assign m1 = PW'(Multiplicand);
   assign m2 = m1 << 1;
   assign m3 = m1 + m2;
   assign m4 = m1 << 2;
   assign m5 = m4 + m1;
   assign m6 = m3 << 1;
   assign m8 = m1 << 3;
   assign m7 = m8 - m1;

   // Window {b3,b2,b1,b0,b-1} -> -8*b3 + 4*b2 + 2*b1 + b0 + b-1.
   assign digit = $signed({Multiplier[4], Multiplier[4:1]})
                + $signed({4'b0, Multiplier[0]});
   assign neg   = digit[4];
   assign abs_d = neg ? 5'(-digit) : 5'(digit);

   always_comb begin
      mag_pp = '0;
      unique case (abs_d)
         5'd1:    mag_pp = m1;
         5'd2:    mag_pp = m2;
         5'd3:    mag_pp = m3;
         5'd4:    mag_pp = m4;
         5'd5:    mag_pp = m5;
         5'd6:    mag_pp = m6;
         5'd7:    mag_pp = m7;
         5'd8:    mag_pp = m8;
         default: mag_pp = '0;
      endcase
   end

   assign Partial = neg ? (~mag_pp + 1'b1) : mag_pp;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential unsigned multiplier, one radix-16 Booth digit per cycle.
// Define BOOTH_SEQ_EARLY_TERM_EN to finish once the remaining digits are zero.
module booth_mul_seq
   import fp_pkg::*;
#(
   parameter int WIDTH = 24
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 IN_VALID,
   output logic                 IN_READY,
   input  logic [WIDTH-1:0]     A,
   input  logic [WIDTH-1:0]     B,
   output logic                 OUT_VALID,
   input  logic                 OUT_READY,
   output logic [2*WIDTH-1:0]   PRODUCT,
   output logic                 BUSY
);

   localparam int N    = NUM_DIGITS(WIDTH);
   localparam int CW   = $clog2(N + 1);
   localparam int EXT  = 4 * N + 1;
   localparam int PW   = WIDTH + 4;
   localparam int ACCW = 2 * WIDTH + 4;
   localparam int PAD  = EXT - WIDTH - 1;

   state_t            state_q, state_d;
   logic [WIDTH-1:0]  a_q;
   logic [EXT-1:0]    bext_q;
   logic [ACCW-1:0]   acc_q;
   logic [CW-1:0]     cnt_q;

   logic [CW+1:0]     sh;
   logic [4:0]        win;
   logic [PW-1:0]     pp;
   logic [ACCW-1:0]   pp_ext;
   logic [ACCW-1:0]   addend;
   logic              accept;
   logic              last;
   logic              run_done;
   logic              unused_acc;

   assign sh  = {cnt_q, 2'b00};
   assign win = 5'(bext_q >> sh);

   Radix16_Booth #(
      .WIDTH        (WIDTH)
   ) u_booth (
      .Multiplicand (a_q),
      .Multiplier   (win),
      .Partial      (pp)
   );

   assign pp_ext = {{(ACCW-PW){pp[PW-1]}}, pp};
   assign addend = pp_ext << sh;
   assign last   = (cnt_q == CW'(N - 1));

`ifdef BOOTH_SEQ_EARLY_TERM_EN
   logic [CW+1:0] sh_hi;
   assign sh_hi    = sh + (CW+2)'(4);
   assign run_done = last | ((bext_q >> sh_hi) == '0);
`else
   assign run_done = last;
`endif

   assign IN_READY  = (state_q == ST_IDLE)
                    | ((state_q == ST_DONE) & OUT_READY);
   assign accept    = IN_VALID & IN_READY;
   assign OUT_VALID = (state_q == ST_DONE);
   assign BUSY      = (state_q == ST_RUN);
   assign PRODUCT   = OUT_VALID ? acc_q[2*WIDTH-1:0] : '0;

   // Top guard bits only absorb the modular wrap of negative digits.
   assign unused_acc = ^acc_q[ACCW-1:2*WIDTH];

   always_ff @(posedge CLK) begin
      if (RST) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_RUN;
         end
         ST_RUN: begin
            if (run_done) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (OUT_READY) state_d = accept ? ST_RUN : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         a_q    <= '0;
         bext_q <= '0;
         acc_q  <= '0;
         cnt_q  <= '0;
      end else if (accept) begin
         a_q    <= A;
         bext_q <= {{PAD{1'b0}}, B, 1'b0};
         acc_q  <= '0;
         cnt_q  <= '0;
      end else if (state_q == ST_RUN) begin
         acc_q  <= acc_q + addend;
         cnt_q  <= cnt_q + CW'(1);
      end
   end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed and scoreboarded checks for booth_mul_seq (WIDTH=24).
module tb_booth_mul_seq;

   localparam int W = 24;

   logic          CLK;
   logic          RST;
   logic          IN_VALID;
   logic          IN_READY;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          OUT_VALID;
   logic          OUT_READY;
   logic [2*W-1:0] PRODUCT;
   logic          BUSY;

   int n_tests = 0;
   int n_fail  = 0;

   booth_mul_seq #(.WIDTH(W)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .A         (A),
      .B         (B),
      .OUT_VALID (OUT_VALID),
      .OUT_READY (OUT_READY),
      .PRODUCT   (PRODUCT),
      .BUSY      (BUSY)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Issue one op with OUT_READY high; return latency and the product seen.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [2*W-1:0] prod);
      A = a; B = b; IN_VALID = 1'b1; OUT_READY = 1'b1;
      tick();
      IN_VALID = 1'b0;
      A = ~a; B = ~b;
      lat = 0;
      prod = '0;
      for (int k = 0; k < 20; k++) begin
         tick();
         lat++;
         if (OUT_VALID) begin
            prod = PRODUCT;
            break;
         end
      end
      tick();
   endtask

   int              lat;
   int              lat_exp;
   int              seen;
   int              sent;
   int              got;
   int              cyc;
   logic [2*W-1:0]  prod;
   logic [2*W-1:0]  held;
   logic [2*W-1:0]  exp_q[$];
   logic [2*W-1:0]  e;
   logic [W-1:0]    ra;
   logic [W-1:0]    rb;

   initial begin
      RST = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
      A = '0; B = '0;
      tick();
      tick();
      RST = 1'b0;
      #1;
      chk("rst_in_ready", 64'(IN_READY), 64'd1);
      chk("rst_out_valid", 64'(OUT_VALID), 64'd0);
      chk("rst_busy", 64'(BUSY), 64'd0);
      chk("rst_product", 64'(PRODUCT), 64'd0);

      run_op(24'h800000, 24'h800000, lat, prod);
      chk("msb_lat", 64'(lat), 64'd7);
      chk("msb_prod", 64'(prod), 64'h400000000000);

      run_op(24'hFFFFFF, 24'hFFFFFF, lat, prod);
      chk("max_prod", 64'(prod), 64'hFFFFFE000001);

      run_op(24'h000001, 24'hABCDEF, lat, prod);
      chk("one_prod", 64'(prod), 64'h000000ABCDEF);

      run_op(24'h000000, 24'h5A5A5A, lat, prod);
      chk("zero_prod", 64'(prod), 64'h0);

`ifdef BOOTH_SEQ_EARLY_TERM_EN
      lat_exp = 1;
`else
      lat_exp = 7;
`endif
      run_op(24'h123456, 24'h000003, lat, prod);
      chk("small_lat", 64'(lat), 64'(lat_exp));
      chk("small_prod", 64'(prod), 64'h369D02);

      // Stall in DONE while the next pair is already offered.
      A = 24'h00F00D; B = 24'h000100; IN_VALID = 1'b1; OUT_READY = 1'b0;
      tick();
      A = 24'h000002; B = 24'h000003;
      for (int k = 0; k < 20 && !OUT_VALID; k++) tick();
      chk("stall_first_valid", 64'(OUT_VALID), 64'd1);
      held = PRODUCT;
      chk("stall_first_prod", 64'(held), 64'h00F00D00);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stall_valid", 64'(OUT_VALID), 64'd1);
         chk("stall_prod", 64'(PRODUCT), 64'h00F00D00);
         chk("stall_in_ready", 64'(IN_READY), 64'd0);
      end
      OUT_READY = 1'b1;
      #1;
      chk("release_in_ready", 64'(IN_READY), 64'd1);
      tick();
      IN_VALID = 1'b0;
      chk("b2b_busy", 64'(BUSY), 64'd1);
      chk("b2b_out_valid", 64'(OUT_VALID), 64'd0);
      chk("b2b_prod_zero", 64'(PRODUCT), 64'd0);
      for (int k = 0; k < 20 && !OUT_VALID; k++) tick();
      chk("b2b_prod", 64'(PRODUCT), 64'd6);
      tick();

      // Reset in the third RUN cycle aborts the operation.
      A = 24'hABCDEF; B = 24'hFEDCBA; IN_VALID = 1'b1; OUT_READY = 1'b1;
      tick();
      IN_VALID = 1'b0;
      tick();
      tick();
      chk("abort_busy", 64'(BUSY), 64'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      chk("abort_in_ready", 64'(IN_READY), 64'd1);
      chk("abort_out_valid", 64'(OUT_VALID), 64'd0);
      chk("abort_busy_low", 64'(BUSY), 64'd0);
      chk("abort_prod", 64'(PRODUCT), 64'd0);
      seen = 0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (OUT_VALID) seen++;
      end
      chk("abort_no_result", 64'(seen), 64'd0);

      // Back-to-back random pairs with random consumer stalls.
      sent = 0; got = 0; cyc = 0;
      while (got < 1000 && cyc < 40000) begin
         ra = W'($urandom);
         rb = W'($urandom);
         if ($urandom_range(0, 7) == 0) rb = W'($urandom_range(0, 255));
         A = ra; B = rb;
         IN_VALID = (sent < 1000);
         OUT_READY = ($urandom_range(0, 3) != 0);
         #1;
         if (OUT_VALID && OUT_READY) begin
            if (exp_q.size() == 0) begin
               chk("rand_unexpected", 64'(PRODUCT), 64'hDEAD);
            end else begin
               e = exp_q.pop_front();
               chk("rand_prod", 64'(PRODUCT), 64'(e));
            end
            got++;
         end
         if (IN_VALID && IN_READY) begin
            exp_q.push_back((2*W)'(ra) * (2*W)'(rb));
            sent++;
         end
         tick();
         cyc++;
      end
      chk("rand_count", 64'(got), 64'd1000);
      chk("rand_drained", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
